spi_slave_regif: RTL and testbench
==================================

Name: spi_slave_regif

Overview:
Synthesizable SPI slave that terminates the SPI bus driven by the apb_to_spi master. It oversamples SCLK, SS and MOSI in the system clock domain. It decodes 16-bit frames (8-bit address byte, then 8-bit data byte, MSB first) into single-cycle register-file write and read strobes. For reads it returns register data on MISO during the data byte. It sits directly downstream of the SPI link and feeds the local register block.

Parameters:
CPOL, 0, SCLK idle level.
CPHA, 0, 0: sample on leading edge and shift on trailing edge; 1: the reverse.
SYNC_STAGES, 2, synchronizer depth for SCLK/SS/MOSI (min 2).

Ports:
clk  input  1  system clock; must be at least 8x the SCLK frequency.
rst  input  1  asynchronous, active-high reset.
spi_sclk  input  1  SPI clock.
spi_ss_n  input  1  slave select, active low.
spi_mosi  input  1  master-out data.
spi_miso  output  1  slave-out data.
spi_miso_oe  output  1  MISO output enable.
reg_addr  output  7  register address, from address byte bits [6:0].
reg_wdata  output  8  write data.
reg_wr_en  output  1  one-cycle write strobe.
reg_rd_en  output  1  one-cycle read strobe.
reg_rdata  input  8  read data, valid the cycle after reg_rd_en.
frame_err  output  1  one-cycle pulse when SS rises before 16 bits.
busy  output  1  high from frame start until SS returns high.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; shift registers and bit counter 0.
- Synchronizer flops reset to 0.
  - A frame therefore starts only on a genuine high-to-low SS transition after reset.
  - If SS is already low when reset releases, the device waits for SS high and then low again.
- Edge selection:
  - sample_edge is the rising synchronized SCLK edge when CPOL^CPHA==0, else the falling edge.
  - shift_edge is the opposite edge.
  - All edge events are single-clk pulses from the sync/edge sub-module.
- FSM states: IDLE, ADDR, DATA, WAIT_SS.
  - IDLE: on detected SS fall, go to ADDR, clear bit_cnt, set busy=1.
  - ADDR: on each sample_edge, shift MOSI into rx_sr and increment bit_cnt. On the 8th bit:
    - latch reg_addr = rx_sr[6:0] and the rw flag = bit 7 (1 = read);
    - go to DATA;
    - if read, pulse reg_rd_en in the next cycle. The cycle after that, load tx_sr from reg_rdata and set spi_miso_oe=1.
  - DATA: on each sample_edge, shift MOSI into rx_sr.
    - On each shift_edge, shift tx_sr left. The first shift_edge seen in DATA does not shift, so bit 7 stays on MISO for the first sample; this holds for both CPHA values.
    - spi_miso = tx_sr[7] when oe is set, else 0.
    - On the 16th bit, go to WAIT_SS. If write: reg_wdata = rx byte and reg_wr_en pulses the next cycle.
  - WAIT_SS: further SCLK edges are ignored. On SS rise, go to IDLE with busy=0, spi_miso_oe=0 and spi_miso=0.
- SS rise in ADDR or DATA:
  - pulse frame_err for 1 cycle and return to IDLE;
  - no reg_wr_en is issued;
  - a reg_rd_en that was already issued is not retracted.
- SS rise and a sample_edge in the same cycle: SS wins; the bit is discarded.
- Latency from the physical 16th sample edge to reg_wr_en: SYNC_STAGES+2 clk.
- rst asserted mid-frame: immediate return to IDLE with outputs at reset values; no strobes are issued.

Decomposition:
- Package spi_pkg holds:
  - state_t enum (IDLE, ADDR, DATA, WAIT_SS);
  - SPI_ADDR_W=8, SPI_DATA_W=8, SPI_FRAME_BITS=16;
  - SPI_RW_BIT=7;
  - function sample_on_rise(cpol, cpha).
- One sub-module, spi_sync_edge: a SYNC_STAGES-deep synchronizer plus edge detect that outputs the level, a rise pulse and a fall pulse. It is instantiated for SCLK, SS and MOSI (level only for MOSI).

Test Plan:
- Mode 0 write: frame 0x05, 0xA5 -> one reg_wr_en with reg_addr=0x05 and reg_wdata=0xA5; frame_err=0; busy drops after SS rises.
- Mode 0 read: frame 0x85, dummy 0x00, with reg_rdata=0x3C after reg_rd_en -> reg_rd_en once with reg_addr=0x05; master samples 0x3C on MISO; no reg_wr_en.
- Abort: SS rises after 5 address bits -> frame_err pulses once, no strobes. The next full frame 0x12, 0x34 writes correctly.
- Reset with SS held low: rst pulses mid-frame -> no strobes. 16 clocks without an SS toggle are ignored. After SS goes high and then low, frame 0x01, 0xFF writes normally.
- CPOL=1, CPHA=1 instance: write 0x7F, 0x5A and read 0xFF returning 0xC3 -> correct strobes and MISO data 0xC3.
- 20 SCLK cycles in one SS window carrying 0x02, 0x66 -> exactly one write of 0x66 to 0x02; extra bits ignored. A back-to-back second frame is also accepted.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register interface.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        WAIT_SS = 2'd3
    } state_t;

    localparam int SPI_ADDR_W     = 8;
    localparam int SPI_DATA_W     = 8;
    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_RW_BIT     = 7;

    // Bits are captured on the rising SCLK edge when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol ^ cpha) == 1'b0;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_regif.sv
// Oversampling SPI slave: decodes 16-bit address/data frames into single-cycle
// register-file read and write strobes and returns read data on MISO.
module spi_slave_regif
    import spi_pkg::*;
#(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [6:0]            reg_addr,
    output logic [SPI_DATA_W-1:0] reg_wdata,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [SPI_DATA_W-1:0] reg_rdata,
    output logic                  frame_err,
    output logic                  busy
);

    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_unused_sclk_lvl;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_unused_ss_lvl;
    logic w_mosi;
    logic w_unused_mosi_rise;
    logic w_unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .i_d     (spi_sclk),
        .o_level (w_unused_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk     (clk),
        .rst     (rst),
        .i_d     (spi_ss_n),
        .o_level (w_unused_ss_lvl),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .i_d     (spi_mosi),
        .o_level (w_mosi),
        .o_rise  (w_unused_mosi_rise),
        .o_fall  (w_unused_mosi_fall)
    );

    logic w_sample;
    logic w_shift;

    assign w_sample = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
    assign w_shift  = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;

    state_t                r_state;
    state_t                w_next_state;
    logic [4:0]            r_bit_cnt;
    logic [SPI_DATA_W-2:0] r_rx_sr;
    logic [SPI_DATA_W-1:0] w_rx_next;
    logic [SPI_DATA_W-1:0] r_tx_sr;
    logic [6:0]            r_addr;
    logic [SPI_DATA_W-1:0] r_wdata;
    logic                  r_rw;
    logic                  r_rd_en;
    logic                  r_rd_dly;
    logic                  r_wr_pend;
    logic                  r_wr_en;
    logic                  r_oe;
    logic                  r_skip_shift;
    logic                  r_frame_err;
    logic                  w_in_frame;
    logic                  w_bit_take;
    logic                  w_last_addr_bit;
    logic                  w_last_data_bit;
    logic                  w_abort;
    logic                  w_busy;
    logic                  w_miso;

    // SS rising in the same cycle as a sample edge discards that bit.
    assign w_in_frame      = (r_state == ADDR) || (r_state == DATA);
    assign w_bit_take      = w_in_frame && w_sample && !w_ss_rise;
    assign w_rx_next       = {r_rx_sr, w_mosi};
    assign w_last_addr_bit = w_bit_take && (r_state == ADDR) &&
                             (r_bit_cnt == 5'(SPI_ADDR_W - 1));
    assign w_last_data_bit = w_bit_take && (r_state == DATA) &&
                             (r_bit_cnt == 5'(SPI_FRAME_BITS - 1));
    assign w_abort         = w_in_frame && w_ss_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) w_next_state = ADDR;
            end
            ADDR: begin
                if (w_ss_rise)            w_next_state = IDLE;
                else if (w_last_addr_bit) w_next_state = DATA;
            end
            DATA: begin
                if (w_ss_rise)            w_next_state = IDLE;
                else if (w_last_data_bit) w_next_state = WAIT_SS;
            end
            WAIT_SS: begin
                if (w_ss_rise) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_miso = r_oe & r_tx_sr[SPI_DATA_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_rx_sr      <= '0;
            r_tx_sr      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rw         <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_dly     <= 1'b0;
            r_wr_pend    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_oe         <= 1'b0;
            r_skip_shift <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rd_en     <= 1'b0;
            r_rd_dly    <= r_rd_en;
            r_wr_pend   <= 1'b0;
            r_wr_en     <= r_wr_pend;
            r_frame_err <= w_abort;

            if (r_state == IDLE && w_ss_fall) begin
                r_bit_cnt <= '0;
                r_rx_sr   <= '0;
            end else if (w_bit_take) begin
                r_rx_sr   <= w_rx_next[SPI_DATA_W-2:0];
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end

            if (w_last_addr_bit) begin
                r_addr       <= w_rx_next[6:0];
                r_rw         <= w_rx_next[SPI_RW_BIT];
                r_rd_en      <= w_rx_next[SPI_RW_BIT];
                r_skip_shift <= 1'b1;
            end

            // The write strobe is held back one cycle after the last bit lands.
            if (w_last_data_bit && !r_rw) begin
                r_wdata   <= w_rx_next;
                r_wr_pend <= 1'b1;
            end

            // Read data arrives the cycle after the read strobe; it only
            // reaches MISO if the frame is still alive.
            if (r_rd_dly && r_state == DATA) begin
                r_tx_sr <= reg_rdata;
                r_oe    <= 1'b1;
            end else if (r_state == DATA && w_shift && !w_ss_rise) begin
                if (r_skip_shift) r_skip_shift <= 1'b0;
                else              r_tx_sr      <= {r_tx_sr[SPI_DATA_W-2:0], 1'b0};
            end

            if (w_ss_rise && r_state != IDLE) begin
                r_oe <= 1'b0;
            end
        end
    end

    assign spi_miso    = w_miso;
    assign spi_miso_oe = r_oe;
    assign busy        = w_busy;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign reg_wr_en   = r_wr_en;
    assign reg_rd_en   = r_rd_en;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: a mode-0 and a mode-3 instance driven by a
// behavioural SPI master, with frame outcomes compared to a frame-level model.
module tb_spi_slave_regif;

    localparam int H  = 8;
    localparam int NI = 2;

    typedef struct packed {
        logic [1:0]  wr_n;
        logic [14:0] wr_val;
        logic [7:0]  lat;
        logic [1:0]  rd_n;
        logic [6:0]  rd_addr;
        logic [1:0]  err_n;
        logic [7:0]  rx;
        logic        busy_mid;
        logic        busy_end;
        logic        oe_end;
    } frame_res_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [1:0] sclk = 2'b10;
    logic [1:0] ss_n = 2'b11;
    logic [1:0] mosi = 2'b00;
    logic [1:0] miso, miso_oe, wr_en, rd_en, ferr, busy;
    logic [6:0] addr  [NI];
    logic [7:0] wdata [NI];
    logic [7:0] rdata [NI] = '{8'h00, 8'h00};
    logic [7:0] rmem  [NI][128];
    logic [1:0] cpol_v = 2'b10;
    logic [1:0] cpha_v = 2'b10;
    int         sync_v  [NI] = '{2, 3};
    int         wr_cnt  [NI] = '{0, 0};
    int         rd_cnt  [NI] = '{0, 0};
    int         err_cnt [NI] = '{0, 0};
    logic [14:0] last_wr   [NI];
    logic [6:0]  last_rd   [NI];
    time         last_wr_t [NI];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_slave_regif #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .rst(rst), .spi_sclk(sclk[0]), .spi_ss_n(ss_n[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .spi_miso_oe(miso_oe[0]), .reg_addr(addr[0]), .reg_wdata(wdata[0]),
        .reg_wr_en(wr_en[0]), .reg_rd_en(rd_en[0]), .reg_rdata(rdata[0]),
        .frame_err(ferr[0]), .busy(busy[0])
    );

    spi_slave_regif #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(3)) u_m3 (
        .clk(clk), .rst(rst), .spi_sclk(sclk[1]), .spi_ss_n(ss_n[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .spi_miso_oe(miso_oe[1]), .reg_addr(addr[1]), .reg_wdata(wdata[1]),
        .reg_wr_en(wr_en[1]), .reg_rd_en(rd_en[1]), .reg_rdata(rdata[1]),
        .frame_err(ferr[1]), .busy(busy[1])
    );

    // Register-file model and strobe monitor.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (wr_en[i]) begin
                wr_cnt[i]++;
                last_wr[i]   = {addr[i], wdata[i]};
                last_wr_t[i] = $time;
            end
            if (rd_en[i]) begin
                rd_cnt[i]++;
                last_rd[i] = addr[i];
                rdata[i] <= rmem[i][addr[i]];
            end
            if (ferr[i]) err_cnt[i]++;
        end
    end

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    // Expected outcome of one SS window carrying nbits bits of {b0, b1, ...}.
    function automatic frame_res_t model(input int i, input logic [7:0] b0, input logic [7:0] b1,
                                         input int nbits);
        frame_res_t e;
        e = '0;
        e.busy_mid = 1'b1;
        if (nbits >= 16 && !b0[7]) begin
            e.wr_n   = 2'd1;
            e.wr_val = {b0[6:0], b1};
            e.lat    = 8'(sync_v[i] + 2);
        end
        if (b0[7] && nbits >= 8) begin
            e.rd_n    = 2'd1;
            e.rd_addr = b0[6:0];
        end
        if (b0[7] && nbits >= 16) e.rx = rmem[i][b0[6:0]];
        if (nbits < 16) e.err_n = 2'd1;
        return e;
    endfunction

    task automatic do_frame(input int i, input logic [7:0] b0, input logic [7:0] b1,
                            input int nbits, output frame_res_t o);
        logic [19:0] bits;
        logic [7:0]  rx;
        int          w0, r0, e0;
        time         t16;
        bits = {b0, b1, 4'($urandom)};
        w0 = wr_cnt[i];
        r0 = rd_cnt[i];
        e0 = err_cnt[i];
        o   = '0;
        rx  = '0;
        t16 = 0;
        ss_n[i] = 1'b0;
        wait_h();
        o.busy_mid = busy[i];
        for (int k = 0; k < nbits; k++) begin
            if (!cpha_v[i]) begin
                mosi[i] = bits[19-k];
                wait_h();
                sclk[i] = ~cpol_v[i];
                if (k == 15) t16 = $time;
                if (k >= 8 && k < 16) rx = {rx[6:0], miso[i]};
                wait_h();
                sclk[i] = cpol_v[i];
            end else begin
                sclk[i] = ~cpol_v[i];
                mosi[i] = bits[19-k];
                wait_h();
                sclk[i] = cpol_v[i];
                if (k == 15) t16 = $time;
                if (k >= 8 && k < 16) rx = {rx[6:0], miso[i]};
                wait_h();
            end
        end
        wait_h();
        ss_n[i] = 1'b1;
        repeat (2 * H) @(negedge clk);
        o.busy_end = busy[i];
        o.oe_end   = miso_oe[i];
        o.wr_n     = 2'(wr_cnt[i] - w0);
        o.rd_n     = 2'(rd_cnt[i] - r0);
        o.err_n    = 2'(err_cnt[i] - e0);
        if (o.wr_n != 0) begin
            o.wr_val = last_wr[i];
            o.lat    = 8'((last_wr_t[i] - t16) / 10);
        end
        if (o.rd_n != 0) o.rd_addr = last_rd[i];
        if (nbits >= 16) o.rx = rx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({miso[i], miso_oe[i], wr_en[i], rd_en[i], ferr[i], busy[i], addr[i], wdata[i]} !== 21'd0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: got %h required 0", i,
                         {miso[i], miso_oe[i], wr_en[i], rd_en[i], ferr[i], busy[i], addr[i], wdata[i]});
            end
        end
        rst = 1'b0;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic test_mode0_write_read();
        frame_res_t o, e;
        do_frame(0, 8'h05, 8'hA5, 16, o);
        e = model(0, 8'h05, 8'hA5, 16);
        checks++;
        if (o !== e) begin errors++; $display("FAIL m0_write: got %h required %h", o, e); end
        rmem[0][5] = 8'h3C;
        do_frame(0, 8'h85, 8'h00, 16, o);
        e = model(0, 8'h85, 8'h00, 16);
        checks++;
        if (o !== e) begin errors++; $display("FAIL m0_read: got %h required %h", o, e); end
    endtask

    task automatic test_abort();
        frame_res_t o, e;
        do_frame(0, 8'h12, 8'h34, 5, o);
        e = model(0, 8'h12, 8'h34, 5);
        checks++;
        if (o !== e) begin errors++; $display("FAIL abort_5bits: got %h required %h", o, e); end
        do_frame(0, 8'h12, 8'h34, 16, o);
        e = model(0, 8'h12, 8'h34, 16);
        checks++;
        if (o !== e) begin errors++; $display("FAIL after_abort: got %h required %h", o, e); end
        rmem[0][8'h21 & 8'h7F] = 8'h9E;
        do_frame(0, 8'hA1, 8'h00, 11, o);
        e = model(0, 8'hA1, 8'h00, 11);
        checks++;
        if (o !== e) begin errors++; $display("FAIL abort_read_data: got %h required %h", o, e); end
    endtask

    task automatic test_reset_ss_low();
        frame_res_t o, e;
        logic [15:0] junk;
        int w0, r0, e0;
        junk = 16'h0A5F;
        w0 = wr_cnt[0];
        r0 = rd_cnt[0];
        e0 = err_cnt[0];
        ss_n[0] = 1'b0;
        wait_h();
        for (int k = 0; k < 5; k++) begin
            mosi[0] = 1'b0;
            wait_h();
            sclk[0] = 1'b1;
            wait_h();
            sclk[0] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy[0], ferr[0], wr_en[0], rd_en[0], miso_oe[0], miso[0], addr[0]} !== 13'd0) begin
            errors++;
            $display("FAIL rst_midframe_outputs: got %h required 0",
                     {busy[0], ferr[0], wr_en[0], rd_en[0], miso_oe[0], miso[0], addr[0]});
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mosi[0] = junk[15-k];
            wait_h();
            sclk[0] = 1'b1;
            wait_h();
            sclk[0] = 1'b0;
        end
        wait_h();
        checks++;
        if ({wr_cnt[0] - w0, rd_cnt[0] - r0, err_cnt[0] - e0} !== 96'd0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ss_low_ignored: wr=%0d rd=%0d err=%0d busy=%b required 0 0 0 0",
                     wr_cnt[0] - w0, rd_cnt[0] - r0, err_cnt[0] - e0, busy[0]);
        end
        ss_n[0] = 1'b1;
        repeat (2 * H) @(negedge clk);
        do_frame(0, 8'h01, 8'hFF, 16, o);
        e = model(0, 8'h01, 8'hFF, 16);
        checks++;
        if (o !== e) begin errors++; $display("FAIL after_ss_relow: got %h required %h", o, e); end
    endtask

    task automatic test_mode3();
        frame_res_t o, e;
        do_frame(1, 8'h7F, 8'h5A, 16, o);
        e = model(1, 8'h7F, 8'h5A, 16);
        checks++;
        if (o !== e) begin errors++; $display("FAIL m3_write: got %h required %h", o, e); end
        rmem[1][8'h7F] = 8'hC3;
        do_frame(1, 8'hFF, 8'h00, 16, o);
        e = model(1, 8'hFF, 8'h00, 16);
        checks++;
        if (o !== e) begin errors++; $display("FAIL m3_read: got %h required %h", o, e); end
    endtask

    task automatic test_back_to_back();
        frame_res_t o, e;
        do_frame(0, 8'h02, 8'h66, 20, o);
        e = model(0, 8'h02, 8'h66, 20);
        checks++;
        if (o !== e) begin errors++; $display("FAIL long_frame_m0: got %h required %h", o, e); end
        do_frame(0, 8'h35, 8'hC7, 16, o);
        e = model(0, 8'h35, 8'hC7, 16);
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_m0: got %h required %h", o, e); end
        do_frame(1, 8'h02, 8'h66, 20, o);
        e = model(1, 8'h02, 8'h66, 20);
        checks++;
        if (o !== e) begin errors++; $display("FAIL long_frame_m3: got %h required %h", o, e); end
    endtask

    task automatic test_random();
        frame_res_t  o, e;
        logic [7:0]  b0, b1;
        int          nb;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NI; i++) begin
                b0 = 8'($urandom);
                b1 = 8'($urandom);
                nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
                do_frame(i, b0, b1, nb, o);
                e = model(i, b0, b1, nb);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL rand_%0d inst%0d b0=%h b1=%h nbits=%0d: got %h required %h",
                             n, i, b0, b1, nb, o, e);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < 128; j++)
                rmem[i][j] = 8'($urandom);
        test_reset();
        test_mode0_write_read();
        test_abort();
        test_reset_ss_low();
        test_mode3();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
